// File: rtl/cp0_exc_unit.sv
// ============================================================================
// cp0_exc_unit: coprocessor-0 registers and precise-exception/interrupt commit
// Revision: 1.0
// ============================================================================
`default_nettype none

module cp0_exc_unit #(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic                  stall_m,
  input  logic [7:0]            except_m,
  input  logic                  is_slot_m,
  input  logic [31:0]           pc_m,
  input  logic [31:0]           bad_addr_m,
  input  logic                  we_m,
  input  logic [4:0]            waddr_m,
  input  logic [31:0]           wdata_m,
  input  logic [4:0]            raddr_d,
  output logic [31:0]           rdata_d,
  input  logic [NUM_HW_INT-1:0] int_i,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
);

  localparam logic [4:0] C_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] C_ADDR_COUNT    = 5'd9;
  localparam logic [4:0] C_ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] C_ADDR_STATUS   = 5'd12;
  localparam logic [4:0] C_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] C_ADDR_EPC      = 5'd14;
  localparam logic [3:0] C_PRESCALE_MAX  = 4'(COUNT_DIV - 1);

  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           epc_q, epc_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [NUM_HW_INT-1:0] int_q;
  logic [3:0]            prescale_q, prescale_d;

  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic [31:0] status_rd, cause_rd;
  logic        int_pend, commit, exc_take, eret_take;
  logic [4:0]  code;
  logic        sel_fetch, sel_data;
  logic        tick, cnt_upd, cmp_wr, mtc0_en;

  // Unused hardware IP bits read as zero; the timer shares IP[15].
  always_comb begin
    hw_ip = '0;
    hw_ip[NUM_HW_INT-1:0] = int_q;
    hw_ip[5] = hw_ip[5] | ti_q;
  end

  assign ip        = {hw_ip, ip_sw_q};
  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

  assign int_pend  = ie_q & ~exl_q & (|(ip & im_q));
  assign commit    = ~rst & valid_m & ~stall_m & (int_pend | (|except_m));
  assign exc_take  = commit & (int_pend | (|{except_m[7:5], except_m[3:0]}));
  assign eret_take = commit & ~exc_take & except_m[4];

  always_comb begin
    code      = 5'h00;
    sel_fetch = 1'b0;
    sel_data  = 1'b0;
    if (int_pend) begin
      code = 5'h00;
    end else if (except_m[7]) begin
      code      = 5'h04;
      sel_fetch = 1'b1;
    end else if (except_m[3]) begin
      code = 5'h0A;
    end else if (except_m[6]) begin
      code = 5'h08;
    end else if (except_m[5]) begin
      code = 5'h09;
    end else if (except_m[2]) begin
      code = 5'h0C;
    end else if (except_m[1]) begin
      code     = 5'h04;
      sel_data = 1'b1;
    end else if (except_m[0]) begin
      code     = 5'h05;
      sel_data = 1'b1;
    end
  end

  assign mtc0_en = we_m & ~stall_m & ~exc_take;
  assign tick    = (prescale_q == C_PRESCALE_MAX);

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    prescale_d = tick ? 4'd0 : prescale_q + 4'd1;
    cnt_upd    = tick;
    cmp_wr     = 1'b0;
    if (tick) count_d = count_q + 32'd1;

    if (exc_take) begin
      exccode_d = code;
      exl_d     = 1'b1;
      if (!exl_q) begin
        epc_d = is_slot_m ? pc_m - 32'd4 : pc_m;
        bd_d  = is_slot_m;
      end
      if (sel_fetch) badvaddr_d = pc_m;
      if (sel_data)  badvaddr_d = bad_addr_m;
    end else if (eret_take) begin
      exl_d = 1'b0;
    end

    if (mtc0_en) begin
      case (waddr_m)
        C_ADDR_COUNT: begin
          count_d    = wdata_m;
          prescale_d = 4'd0;
          cnt_upd    = 1'b1;
        end
        C_ADDR_COMPARE: begin
          compare_d = wdata_m;
          cmp_wr    = 1'b1;
        end
        C_ADDR_STATUS: begin
          im_d  = wdata_m[15:8];
          exl_d = wdata_m[1];
          ie_d  = wdata_m[0];
        end
        C_ADDR_CAUSE: ip_sw_d = wdata_m[9:8];
        C_ADDR_EPC:   epc_d   = wdata_m;
        default: ;
      endcase
    end

    // Match is evaluated only when Count moves, so Count==Compare==0 out of reset stays quiet.
    if (cmp_wr) ti_d = 1'b0;
    else if (cnt_upd && (count_d == compare_d)) ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      int_q      <= '0;
      prescale_q <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      int_q      <= int_i;
      prescale_q <= prescale_d;
    end
  end

  always_comb begin
    case (raddr_d)
      C_ADDR_BADVADDR: rdata_d = badvaddr_q;
      C_ADDR_COUNT:    rdata_d = count_q;
      C_ADDR_COMPARE:  rdata_d = compare_q;
      C_ADDR_STATUS:   rdata_d = status_rd;
      C_ADDR_CAUSE:    rdata_d = cause_rd;
      C_ADDR_EPC:      rdata_d = epc_q;
      default:         rdata_d = 32'd0;
    endcase
  end

  assign flush_o     = exc_take | eret_take;
  assign new_pc_o    = exc_take ? EXC_VECTOR : (eret_take ? epc_q : 32'd0);
  assign epc_o       = epc_q;
  assign timer_int_o = ti_q;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
// ============================================================================
// tb_cp0_exc_unit: directed scoreboard bench for cp0_exc_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cp0_exc_unit;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, stall_m, is_slot_m, we_m;
  logic [7:0]  except_m;
  logic [31:0] pc_m, bad_addr_m, wdata_m, rdata_d, new_pc_o, epc_o;
  logic [4:0]  waddr_m, raddr_d;
  logic [5:0]  int_i;
  logic        flush_o, timer_int_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  cp0_exc_unit #(.NUM_HW_INT(6), .EXC_VECTOR(EXC_VEC), .COUNT_DIV(2)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .stall_m(stall_m),
    .except_m(except_m), .is_slot_m(is_slot_m), .pc_m(pc_m),
    .bad_addr_m(bad_addr_m), .we_m(we_m), .waddr_m(waddr_m),
    .wdata_m(wdata_m), .raddr_d(raddr_d), .rdata_d(rdata_d),
    .int_i(int_i), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .epc_o(epc_o), .timer_int_o(timer_int_o)
  );

  // Monitor: every flush must match the oldest expected redirect.
  always @(negedge clk) begin
    if (flush_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_flush: got new_pc=%h, required no flush", new_pc_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (new_pc_o !== mon_exp) begin
          fails++;
          $display("FAIL flush_pc: got %h, required %h", new_pc_o, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string name);
    raddr_d = a;
    @(negedge clk);
    chk(name, rdata_d, e);
    step();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_m = 1'b1; waddr_m = a; wdata_m = d;
    step();
    we_m = 1'b0;
  endtask

  task automatic instr(input logic [7:0] exc, input logic [31:0] pc, input logic slot,
                       input logic [31:0] bad, input logic flush_exp,
                       input logic [31:0] exp_pc, input string name);
    valid_m = 1'b1; except_m = exc; pc_m = pc; is_slot_m = slot; bad_addr_m = bad;
    if (flush_exp) exp_q.push_back(exp_pc);
    step();
    valid_m = 1'b0; except_m = '0; is_slot_m = 1'b0; we_m = 1'b0;
    if (flush_exp) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL missing_flush %s: got no flush, required new_pc=%h", name, exp_pc);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_m = 1'b1; stall_m = 1'b0; except_m = 8'h40; is_slot_m = 1'b0;
    pc_m = 32'h8000_0100; bad_addr_m = '0; we_m = 1'b0; waddr_m = '0; wdata_m = '0;
    raddr_d = '0; int_i = '0;
    repeat (3) step();
    rst = 1'b0; valid_m = 1'b0; except_m = '0;
    @(negedge clk);
    chk("flush_after_reset", {31'b0, flush_o}, 32'd0);
    chk("newpc_after_reset", new_pc_o, 32'd0);
    rd(5'd12, 32'h0040_0000, "status_reset");
    rd(5'd13, 32'h0000_0000, "cause_reset");
    rd(5'd14, 32'h0000_0000, "epc_reset");
    rd(5'd8,  32'h0000_0000, "badvaddr_reset");
    rd(5'd11, 32'h0000_0000, "compare_reset");
    mtc0(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, 32'h0000_0000, "unmapped_read");

    // Syscall then ERET
    instr(8'h40, 32'h8000_1000, 1'b0, '0, 1'b1, EXC_VEC, "syscall");
    rd(5'd14, 32'h8000_1000, "syscall_epc");
    rd(5'd13, 32'h0000_0020, "syscall_cause");
    rd(5'd12, 32'h0040_0002, "syscall_status");
    chk("syscall_epc_o", epc_o, 32'h8000_1000);
    instr(8'h10, 32'h8000_2000, 1'b0, '0, 1'b1, 32'h8000_1000, "eret1");
    rd(5'd12, 32'h0040_0000, "eret1_status");

    // Data AdES in a delay slot with a concurrent MTC0 to EPC
    we_m = 1'b1; waddr_m = 5'd14; wdata_m = 32'hDEAD_BEEF;
    instr(8'h01, 32'h8000_2004, 1'b1, 32'h8000_0003, 1'b1, EXC_VEC, "ades");
    rd(5'd14, 32'h8000_2000, "ades_epc");
    rd(5'd8,  32'h8000_0003, "ades_badvaddr");
    rd(5'd13, 32'h8000_0014, "ades_cause");
    instr(8'h10, 32'h8000_3000, 1'b0, '0, 1'b1, 32'h8000_2000, "eret2");

    // Fetch AdEL beats overflow and AdES; then a nested syscall
    instr(8'h85, 32'h8000_0006, 1'b0, 32'h1234_5678, 1'b1, EXC_VEC, "multi");
    rd(5'd13, 32'h0000_0010, "multi_cause");
    rd(5'd8,  32'h8000_0006, "multi_badvaddr");
    rd(5'd14, 32'h8000_0006, "multi_epc");
    instr(8'h40, 32'h8000_3000, 1'b1, '0, 1'b1, EXC_VEC, "nested");
    rd(5'd14, 32'h8000_0006, "nested_epc");
    rd(5'd13, 32'h0000_0020, "nested_cause");
    instr(8'h10, 32'h8000_3100, 1'b0, '0, 1'b1, 32'h8000_0006, "eret3");
    rd(5'd12, 32'h0040_0000, "eret3_status");

    // Hardware interrupt held off by stall, then by EXL
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, 32'h0040_0401, "status_write");
    int_i = 6'b000001; valid_m = 1'b1; stall_m = 1'b1; pc_m = 32'h8000_4000;
    repeat (3) step();
    stall_m = 1'b0;
    instr(8'h00, 32'h8000_4000, 1'b0, '0, 1'b1, EXC_VEC, "irq");
    rd(5'd14, 32'h8000_4000, "irq_epc");
    rd(5'd13, 32'h0000_0400, "irq_cause");
    instr(8'h00, 32'h8000_4100, 1'b0, '0, 1'b0, '0, "irq_exl_blocked");
    instr(8'h00, 32'h8000_4104, 1'b0, '0, 1'b0, '0, "irq_exl_blocked2");
    int_i = '0;
    step();
    instr(8'h10, 32'h8000_4200, 1'b0, '0, 1'b1, 32'h8000_4000, "eret_irq");
    mtc0(5'd12, 32'h0000_0000);

    // Timer: Compare=10 with COUNT_DIV=2 matches 20 cycles after Count=0
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    repeat (19) @(posedge clk);
    #1;
    chk("ti_before_match", {31'b0, timer_int_o}, 32'd0);
    step();
    chk("ti_at_match", {31'b0, timer_int_o}, 32'd1);
    rd(5'd9, 32'd10, "count_at_match");
    rd(5'd13, 32'h4000_8000, "cause_ti");

    mtc0(5'd11, 32'd10);
    chk("ti_cleared_by_compare", {31'b0, timer_int_o}, 32'd0);
    mtc0(5'd9, 32'd0);
    repeat (19) @(posedge clk);
    #1;
    we_m = 1'b1; waddr_m = 5'd11; wdata_m = 32'd10;
    step();
    we_m = 1'b0;
    chk("ti_compare_write_wins", {31'b0, timer_int_o}, 32'd0);
    rd(5'd9, 32'd10, "count_match_cycle");

    // Reset asserted during a flush cycle
    mtc0(5'd12, 32'h0000_0401);
    valid_m = 1'b1; except_m = 8'h40; pc_m = 32'h8000_5000; rst = 1'b1;
    @(negedge clk);
    chk("flush_in_reset", {31'b0, flush_o}, 32'd0);
    step();
    rst = 1'b0; valid_m = 1'b0; except_m = '0;
    @(negedge clk);
    chk("newpc_post_reset", new_pc_o, 32'd0);
    rd(5'd9,  32'd0,         "count_post_reset");
    rd(5'd12, 32'h0040_0000, "status_post_reset");
    rd(5'd13, 32'h0000_0000, "cause_post_reset");
    rd(5'd14, 32'h0000_0000, "epc_post_reset");
    rd(5'd8,  32'h0000_0000, "badvaddr_post_reset");
    rd(5'd11, 32'h0000_0000, "compare_post_reset");

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Parametrised coprocessor-0 and precise-exception unit for the 5-stage MIPS core.
- Takes the per-instruction 8-bit exception vector in the memory stage and prioritises it against hardware and timer interrupts.
- Commits Status/Cause/EPC/BadVAddr, then drives a pipeline flush and redirect PC. Also handles ERET.
- Provides the MFC0 read port (decode stage) and the MTC0 write port (memory stage).

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6); mapped to Cause.IP[10 +: NUM_HW_INT], unused IP bits read 0.
- EXC_VECTOR, 32'hBFC00380, redirect PC for every exception and interrupt.
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (1..16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_m  in  1  memory-stage slot holds a real instruction
- stall_m  in  1  memory stage stalled; no commit this cycle
- except_m  in  8  [7] fetch AdEL, [6] syscall, [5] break, [4] eret, [3] reserved instr, [2] overflow, [1] data AdEL, [0] data AdES
- is_slot_m  in  1  memory-stage instruction sits in a branch delay slot
- pc_m  in  32  memory-stage PC
- bad_addr_m  in  32  data address (ALUOutM)
- we_m  in  1  MTC0 write enable
- waddr_m  in  5  MTC0 register number
- wdata_m  in  32  MTC0 data
- raddr_d  in  5  MFC0 register number
- rdata_d  out  32  MFC0 data, combinational
- int_i  in  NUM_HW_INT  hardware interrupts, level, active-high
- flush_o  out  1  flush all stages F..M this cycle
- new_pc_o  out  32  redirect target, valid while flush_o
- epc_o  out  32  current EPC
- timer_int_o  out  1  Cause.TI

Behaviour:
Registers and reset values:
- BadVAddr(8) = 0; read-only.
- Count(9) = 0.
- Compare(11) = 0.
- Status(12) = 32'h0040_0000. Writable bits: IM[15:8], EXL[1], IE[0]. Other bits are hard-wired (BEV=1).
- Cause(13) = 0. Writable bits: IP[9:8] only. BD[31] and ExcCode[6:2] are written by hardware. TI[30] is set on timer match. IP[15:10] = registered int_i, sampled every cycle, plus TI OR'd into IP[15].
- EPC(14) = 0; fully writable.
- Unmapped addresses read 0; writes to unmapped addresses are ignored.
- flush_o = 0 and new_pc_o = 0 during and immediately after reset.

Interrupt and exception selection:
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
- Commit condition: valid_m & ~stall_m & (interrupt pending | any except_m bit).
- Priority, highest first:
  - interrupt (code 0x00)
  - fetch AdEL (0x04)
  - RI (0x0A)
  - syscall (0x08)
  - break (0x09)
  - overflow (0x0C)
  - data AdEL (0x04)
  - data AdES (0x05)
  - eret, which is not an exception and is taken only if no other cause is present.

On exception commit (registers update at the clock edge; flush_o and new_pc_o are combinational in the same cycle):
- Cause.ExcCode is set to the code.
- If Status.EXL = 0: EPC = is_slot_m ? pc_m-4 : pc_m, and Cause.BD = is_slot_m.
- If EXL is already 1, EPC and BD are left unchanged.
- Status.EXL is set to 1.
- BadVAddr = pc_m for fetch AdEL, bad_addr_m for data AdEL/AdES; unchanged otherwise.
- flush_o = 1, new_pc_o = EXC_VECTOR.
- A concurrent MTC0 (we_m) is suppressed.

On ERET commit:
- Status.EXL is cleared.
- flush_o = 1, new_pc_o = EPC, using the current register value.

Other MTC0 and timer rules:
- MTC0 is applied at the clock edge when we_m & ~stall_m and no exception is committed.
- No read bypass: rdata_d shows the pre-write value in the write cycle. The hazard unit stalls MFC0-after-MTC0.
- Count prescaler is mod COUNT_DIV; Count increments when the prescaler wraps and wraps 32'hFFFFFFFF→0.
- An MTC0 to Count overrides the increment and resets the prescaler.
- Timer match: when Count == Compare after update, TI is set and stays set.
- A write to Compare clears TI and wins over a match in the same cycle.
- stall_m = 1 blocks all commits. Interrupts stay pending and are taken when the stall releases.
- Reset mid-flush returns every register to its reset value. No commit happens in the reset cycle.

Test Plan:
- Syscall at pc_m=0x80001000, is_slot_m=0 → flush_o=1, new_pc_o=0xBFC00380. Next cycle: EPC=0x80001000, ExcCode=0x08, EXL=1. A following ERET → new_pc_o=0x80001000, EXL=0.
- Data AdES with bad_addr_m=0x80000003 in a delay slot at pc_m=0x80002004 → EPC=0x80002000, BD=1, BadVAddr=0x80000003, ExcCode=0x05, and the concurrent MTC0 is dropped.
- except_m=8'b1000_0101 (fetch AdEL + overflow + AdES) at pc_m=0x80000006 → ExcCode=0x04, BadVAddr=0x80000006.
- Status=0x0000_0401 (IE=1, IM[10]=1), int_i[0] raised → flush on the first valid, unstalled M cycle with ExcCode=0. With EXL=1 or stall_m=1, no flush until the condition clears.
- COUNT_DIV=2, Compare=10 → TI sets after 20 cycles and timer_int_o=1. An MTC0 to Compare in the match cycle leaves TI=0.
- Nested exception with EXL=1 → EPC unchanged, ExcCode updated. Reset asserted during a flush cycle → all registers return to reset values, flush_o=0 after reset.
